// File: rtl/ddr3_dqs_cal_seq_if.sv
// Memory request/response and PHY config bundle for the DQS calibration sequencer.
// Signal names keep their original direction suffixes as seen from the sequencer.
interface ddr3_dqs_cal_seq_if;
  logic        cfg_valid_o;
  logic [31:0] cfg_o;
  logic        req_valid_o;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic        req_ready_i;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;

  modport master (
    output cfg_valid_o, cfg_o, req_valid_o, req_we_o, req_addr_o, req_wdata_o,
    input  req_ready_i, resp_valid_i, resp_rdata_i
  );

  modport slave (
    input  cfg_valid_o, cfg_o, req_valid_o, req_we_o, req_addr_o, req_wdata_o,
    output req_ready_i, resp_valid_i, resp_rdata_i
  );
endinterface

// File: rtl/ddr3_dqs_cal_seq.sv
// DQS read-capture calibration sequencer: writes a two-word pattern, sweeps the
// DQS tap, reads the pattern back per tap and programs the centre of the widest
// passing window (earliest window wins ties).
module ddr3_dqs_cal_seq #(
  parameter int unsigned NUM_TAPS      = 32,
  parameter logic [4:0]  DQ_TAP        = 5'd0,
  parameter logic [4:0]  DQS_TAP_DFLT  = 5'd27,
  parameter logic [31:0] CAL_ADDR      = 32'h80,
  parameter logic [31:0] PATTERN       = 32'hA5A5A5A5,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] tap_o,
  output logic [5:0] win_len_o,
  ddr3_dqs_cal_seq_if.master bus
);

  localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned SET_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]  LAST_TAP = 5'(NUM_TAPS - 1);
  localparam logic [31:0] ADDR1    = CAL_ADDR + 32'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_WR0, S_WR1, S_CFG, S_SETTLE, S_RD0, S_RD1, S_EVAL, S_APPLY, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [4:0]       tap_out_q, tap_out_d;
  logic [5:0]       win_len_q, win_len_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [31:0]      cfg_q, cfg_d;
  logic             req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [31:0]      req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic             wait_q, wait_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [4:0]       tap_q, tap_d, run_start_q, run_start_d, best_start_q, best_start_d;
  logic [5:0]       run_len_q, run_len_d, best_len_q, best_len_d;
  logic             rd0_ok_q, rd0_ok_d, tap_ok_q, tap_ok_d, wr_to_q, wr_to_d;

  logic resp_ok, tmo_hit;

  function automatic logic [31:0] cfg_word(input logic [4:0] dqs);
    return {19'b0, DQ_TAP, 3'b0, dqs};
  endfunction

  function automatic logic [4:0] centre(input logic [4:0] s, input logic [5:0] l);
    logic [5:0] half;
    half = (l - 6'd1) >> 1;
    return (l == 6'd0) ? DQS_TAP_DFLT : s + half[4:0];
  endfunction

  // Next-state, request handshake, window tracking and output computation.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    tap_out_d    = tap_out_q;
    win_len_d    = win_len_q;
    cfg_valid_d  = 1'b0;
    cfg_d        = cfg_q;
    req_valid_d  = req_valid_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    wait_d       = wait_q;
    tmo_d        = tmo_q;
    settle_d     = settle_q;
    tap_d        = tap_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    rd0_ok_d     = rd0_ok_q;
    tap_ok_d     = tap_ok_q;
    wr_to_d      = wr_to_q;

    // Single outstanding request: accept, then wait for one response or timeout.
    resp_ok = wait_q & bus.resp_valid_i;
    tmo_hit = wait_q & ~bus.resp_valid_i & (tmo_q == TMO_LAST);
    if (req_valid_q && bus.req_ready_i) begin
      req_valid_d = 1'b0;
      wait_d      = 1'b1;
      tmo_d       = '0;
    end else if (wait_q) begin
      if (resp_ok || tmo_hit) wait_d = 1'b0;
      else                    tmo_d  = tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          tap_out_d    = '0;
          win_len_d    = '0;
          tap_d        = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          wr_to_d      = 1'b0;
          req_valid_d  = 1'b1;
          req_we_d     = 1'b1;
          req_addr_d   = CAL_ADDR;
          req_wdata_d  = PATTERN;
          state_d      = S_WR0;
        end
      end
      S_WR0, S_WR1: begin
        if (resp_ok) begin
          if (state_q == S_WR0) begin
            req_valid_d = 1'b1;
            req_we_d    = 1'b1;
            req_addr_d  = ADDR1;
            req_wdata_d = ~PATTERN;
            state_d     = S_WR1;
          end else begin
            cfg_valid_d = 1'b1;
            cfg_d       = cfg_word(tap_q);
            state_d     = S_CFG;
          end
        end else if (tmo_hit) begin
          wr_to_d     = 1'b1;
          cfg_valid_d = 1'b1;
          cfg_d       = cfg_word(DQS_TAP_DFLT);
          state_d     = S_APPLY;
        end
      end
      S_CFG: begin
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SET_LAST) begin
          req_valid_d = 1'b1;
          req_we_d    = 1'b0;
          req_addr_d  = CAL_ADDR;
          req_wdata_d = '0;
          state_d     = S_RD0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_RD0: begin
        if (resp_ok) begin
          rd0_ok_d    = (bus.resp_rdata_i == PATTERN);
          req_valid_d = 1'b1;
          req_we_d    = 1'b0;
          req_addr_d  = ADDR1;
          req_wdata_d = '0;
          state_d     = S_RD1;
        end else if (tmo_hit) begin
          tap_ok_d = 1'b0;
          state_d  = S_EVAL;
        end
      end
      S_RD1: begin
        if (resp_ok) begin
          tap_ok_d = rd0_ok_q & (bus.resp_rdata_i == ~PATTERN);
          state_d  = S_EVAL;
        end else if (tmo_hit) begin
          tap_ok_d = 1'b0;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        // Best is updated as soon as the open run becomes strictly longer, which
        // gives the same result as comparing only when a run closes.
        if (tap_ok_q) begin
          run_len_d = run_len_q + 6'd1;
          if (run_len_q == 6'd0) run_start_d = tap_q;
          if (run_len_d > best_len_q) begin
            best_len_d   = run_len_d;
            best_start_d = run_start_d;
          end
        end else begin
          run_len_d = '0;
        end
        cfg_valid_d = 1'b1;
        if (tap_q == LAST_TAP) begin
          cfg_d   = cfg_word(centre(best_start_d, best_len_d));
          state_d = S_APPLY;
        end else begin
          tap_d   = tap_q + 5'd1;
          cfg_d   = cfg_word(tap_q + 5'd1);
          state_d = S_CFG;
        end
      end
      S_APPLY: begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        pass_d    = ~wr_to_q & (best_len_q != 6'd0);
        tap_out_d = cfg_q[4:0];
        win_len_d = best_len_q;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any sweep or request in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      tap_out_q    <= '0;
      win_len_q    <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_q        <= '0;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      wait_q       <= 1'b0;
      tmo_q        <= '0;
      settle_q     <= '0;
      tap_q        <= '0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      rd0_ok_q     <= 1'b0;
      tap_ok_q     <= 1'b0;
      wr_to_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      tap_out_q    <= tap_out_d;
      win_len_q    <= win_len_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_q        <= cfg_d;
      req_valid_q  <= req_valid_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      wait_q       <= wait_d;
      tmo_q        <= tmo_d;
      settle_q     <= settle_d;
      tap_q        <= tap_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      rd0_ok_q     <= rd0_ok_d;
      tap_ok_q     <= tap_ok_d;
      wr_to_q      <= wr_to_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign tap_o           = tap_out_q;
  assign win_len_o       = win_len_q;
  assign bus.cfg_valid_o = cfg_valid_q;
  assign bus.cfg_o       = cfg_q;
  assign bus.req_valid_o = req_valid_q;
  assign bus.req_we_o    = req_we_q;
  assign bus.req_addr_o  = req_addr_q;
  assign bus.req_wdata_o = req_wdata_q;

endmodule

// File: tb/tb_ddr3_dqs_cal_seq.sv
// Self-checking bench for ddr3_dqs_cal_seq: a randomized memory responder whose
// read data is corrupted on taps outside a pass mask, a window-search model and
// a per-cycle monitor of the cfg/request streams.
module tb_ddr3_dqs_cal_seq;
  localparam int          NT       = 32;
  localparam logic [31:0] CAL_ADDR = 32'h80;
  localparam logic [31:0] PATTERN  = 32'hA5A5A5A5;
  localparam int          SETTLE   = 16;
  localparam int          TMO      = 1024;
  localparam logic [4:0]  DFLT     = 5'd27;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;

  logic       clk = 1'b0;
  logic       rst_i, start_i;
  logic       busy_o, done_o, pass_o;
  logic [4:0] tap_o;
  logic [5:0] win_len_o;

  ddr3_dqs_cal_seq_if bus_if();

  ddr3_dqs_cal_seq #(
    .NUM_TAPS(NT), .DQ_TAP(5'd0), .DQS_TAP_DFLT(DFLT), .CAL_ADDR(CAL_ADDR),
    .PATTERN(PATTERN), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .tap_o(tap_o), .win_len_o(win_len_o), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  logic [31:0] pass_mask = '0;
  bit          withhold_wr = 1'b0, stray = 1'b0;
  int          hold_left = 0;
  req_t        exp_req[$];
  logic [31:0] exp_cfg[$];
  int          cyc = 0, last_cfg_cyc = 0, acc_cyc = 0;
  logic [4:0]  cur_tap = '0;
  logic [31:0] m0 = '0, m1 = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected", name);
  endtask

  function automatic logic [127:0] outs();
    return {15'b0, busy_o, done_o, pass_o, tap_o, win_len_o, bus_if.cfg_valid_o, bus_if.cfg_o,
            bus_if.req_valid_o, bus_if.req_we_o, bus_if.req_addr_o, bus_if.req_wdata_o};
  endfunction

  // Widest run of set bits, scanning every start position; earliest wins ties.
  function automatic void model(input logic [31:0] mask, output logic [4:0] tap,
                                output logic [5:0] len, output logic ok);
    int bs = 0, bl = 0;
    for (int s = 0; s < NT; s++) begin
      int l = 0;
      while (s + l < NT && mask[s + l]) l++;
      if (l > bl) begin bl = l; bs = s; end
    end
    len = 6'(bl);
    ok  = (bl > 0);
    tap = (bl > 0) ? 5'(bs + (bl - 1) / 2) : DFLT;
  endfunction

  // Memory responder and per-cycle monitor.
  initial begin : mon
    int          pend = 0;
    logic [31:0] pend_data = '0;
    bit          pv = 0, stalled = 0, pw = 0;
    logic [31:0] pa = '0, pd = '0, data;
    logic [1:0]  fail_sel = 2'b01;
    req_t        r, e;
    bus_if.req_ready_i  = 1'b0;
    bus_if.resp_valid_i = 1'b0;
    bus_if.resp_rdata_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus_if.resp_valid_i = 1'b0;
      if (rst_i) begin
        pend = 0; stalled = 0; pv = 0;
        bus_if.req_ready_i = 1'b0;
        continue;
      end
      if (stray) begin
        bus_if.resp_valid_i = 1'b1;
        bus_if.resp_rdata_i = $urandom;
        stray = 1'b0;
      end
      check("cfg_req_overlap", 128'(bus_if.cfg_valid_o & bus_if.req_valid_o), 128'(0));
      check("busy_done_both", 128'(busy_o & done_o), 128'(0));
      if (stalled)
        check("req_stable", {bus_if.req_valid_o, bus_if.req_we_o, bus_if.req_addr_o, bus_if.req_wdata_o},
              {1'b1, pw, pa, pd});
      if (bus_if.req_valid_o && !pv && !bus_if.req_we_o && bus_if.req_addr_o == CAL_ADDR)
        check("settle_gap", 128'(cyc - last_cfg_cyc), 128'(SETTLE + 1));
      if (bus_if.cfg_valid_o) begin
        if (exp_cfg.size() == 0) fail_now("cfg_unexpected");
        else check("cfg_value", 128'(bus_if.cfg_o), 128'(exp_cfg.pop_front()));
        cur_tap      = bus_if.cfg_o[4:0];
        fail_sel     = 2'($urandom_range(1, 3));
        last_cfg_cyc = cyc;
        if (withhold_wr)
          check("wr_timeout_time", 128'((cyc - acc_cyc >= TMO + 1) && (cyc - acc_cyc <= TMO + 3)), 128'(1));
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus_if.resp_valid_i = 1'b1;
          bus_if.resp_rdata_i = pend_data;
        end
      end
      if (hold_left > 0) begin
        bus_if.req_ready_i = 1'b0;
        hold_left--;
      end else begin
        bus_if.req_ready_i = ($urandom_range(0, 3) != 0);
      end
      stalled = bus_if.req_valid_o && !bus_if.req_ready_i;
      pv = bus_if.req_valid_o; pw = bus_if.req_we_o; pa = bus_if.req_addr_o; pd = bus_if.req_wdata_o;
      if (bus_if.req_valid_o && bus_if.req_ready_i) begin
        r = {bus_if.req_we_o, bus_if.req_addr_o, bus_if.req_wdata_o};
        if (!r.we) r.wdata = '0;
        if (exp_req.size() == 0) fail_now("req_unexpected");
        else begin
          e = exp_req.pop_front();
          check("req_fields", 128'(r), 128'(e));
        end
        if (r.we) begin
          if (r.addr == CAL_ADDR) m0 = r.wdata; else m1 = r.wdata;
          acc_cyc = cyc;
          if (!withhold_wr) begin pend = $urandom_range(1, 4); pend_data = $urandom; end
        end else begin
          data = (r.addr == CAL_ADDR) ? m0 : m1;
          if (!pass_mask[cur_tap]) begin
            if (r.addr == CAL_ADDR && fail_sel[0]) data = data ^ (32'd1 << $urandom_range(0, 31));
            if (r.addr != CAL_ADDR && fail_sel[1]) data = data ^ (32'd1 << $urandom_range(0, 31));
          end
          pend_data = data;
          pend = $urandom_range(1, 4);
        end
      end
    end
  end

  task automatic setup_exp(input logic [31:0] mask, input bit wh, output logic [4:0] mt,
                           output logic [5:0] ml, output logic mp);
    model(mask, mt, ml, mp);
    if (wh) begin mt = DFLT; ml = '0; mp = 1'b0; end
    exp_req.delete();
    exp_cfg.delete();
    exp_req.push_back({1'b1, CAL_ADDR, PATTERN});
    if (!wh) begin
      exp_req.push_back({1'b1, CAL_ADDR + 32'd4, ~PATTERN});
      for (int t = 0; t < NT; t++) begin
        exp_cfg.push_back(32'(t));
        exp_req.push_back({1'b0, CAL_ADDR, 32'h0});
        exp_req.push_back({1'b0, CAL_ADDR + 32'd4, 32'h0});
      end
    end
    exp_cfg.push_back(32'(mt));
    pass_mask   = mask;
    withhold_wr = wh;
  endtask

  task automatic run_cal(input logic [31:0] mask, input bit wh, input int hold, input bit pulse_busy,
                         input bit lit, input logic [4:0] ltap, input logic [5:0] llen, input logic lpass);
    logic [4:0] mt;
    logic [5:0] ml;
    logic       mp;
    int         i;
    setup_exp(mask, wh, mt, ml, mp);
    if (lit) begin
      check("model_tap", 128'(mt), 128'(ltap));
      check("model_len", 128'(ml), 128'(llen));
      check("model_pass", 128'(mp), 128'(lpass));
    end
    hold_left = hold;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("start_status", {busy_o, done_o, pass_o}, {1'b1, 1'b0, 1'b0});
    i = 0;
    while (!done_o && i < 20000) begin
      start_i = pulse_busy && (i % 97 == 50);
      @(negedge clk);
      i++;
    end
    start_i = 1'b0;
    if (!done_o) fail_now("done_timeout");
    check("final_status", {busy_o, pass_o, win_len_o, tap_o}, {1'b0, mp, ml, mt});
    check("final_cfg", 128'(bus_if.cfg_o), 128'(mt));
    if (lit) check("final_literal", {pass_o, win_len_o, tap_o}, {lpass, llen, ltap});
    check("cfg_left", 128'(exp_cfg.size()), 128'(0));
    check("req_left", 128'(exp_req.size()), 128'(0));
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] win(input int s, input int l);
    logic [31:0] m = '0;
    for (int t = s; t < s + l && t < NT; t++) m[t] = 1'b1;
    return m;
  endfunction

  initial begin : main
    logic [4:0] mt;
    logic [5:0] ml;
    logic       mp;
    int         i;
    rst_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("reset_state", outs(), 128'(0));
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_after_reset", outs(), 128'(0));

    run_cal(win(10, 11), 0, 0, 0, 1, 5'd15, 6'd11, 1'b1);
    run_cal(win(2, 4) | win(20, 4), 0, 0, 0, 1, 5'd3, 6'd4, 1'b1);
    run_cal(win(2, 4) | win(20, 6), 0, 0, 0, 1, 5'd22, 6'd6, 1'b1);
    run_cal(32'h0, 0, 0, 0, 1, 5'd27, 6'd0, 1'b0);
    check("all_fail_cfg", 128'(bus_if.cfg_o), 128'(32'h0000001B));
    run_cal(win(28, 4), 0, 0, 0, 1, 5'd29, 6'd4, 1'b1);
    run_cal(win(5, 9), 1, 0, 0, 1, 5'd27, 6'd0, 1'b0);
    run_cal(win($urandom_range(0, 31), $urandom_range(1, 12)), 0, 50, 1, 0, '0, '0, 1'b0);

    // Abort during settle of tap 7, then a stray response in idle, then a clean rerun.
    setup_exp(win(4, 8), 0, mt, ml, mp);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    i = 0;
    while (!(bus_if.cfg_valid_o && bus_if.cfg_o[4:0] == 5'd7) && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 5000) fail_now("tap7_timeout");
    repeat (5) @(negedge clk);
    #2 rst_i = 1'b1;
    #1 check("reset_async", outs(), 128'(0));
    exp_req.delete();
    exp_cfg.delete();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    stray = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_after_stray", outs(), 128'(0));
    end
    run_cal(win(4, 8), 0, 0, 0, 1, 5'd7, 6'd8, 1'b1);

    for (int k = 0; k < 4; k++) begin
      logic [31:0] m;
      m = (k % 2 == 0) ? ($urandom & $urandom)
                       : (win($urandom_range(0, 31), $urandom_range(1, 10)) |
                          win($urandom_range(0, 31), $urandom_range(1, 10)));
      run_cal(m, 0, 0, k == 1, 0, '0, '0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
